uart_rom_loader: RTL and testbench

UART_ROM_LOADER -- requirements
Module: uart_rom_loader

---
 rtl/uart_rom_loader_if.sv | 11 +
 rtl/uart_rom_loader.sv | 139 +++++++++++++
 tb/tb_uart_rom_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rom_loader_if.sv
// uart_rom_loader_if: word handoff between the UART ROM loader and the ROM consumer
interface uart_rom_loader_if;
    logic        load;
    logic [15:0] data;
    logic        valid;
    logic        ack;
    logic        load_received;

    modport master (output load, data, valid, input ack, load_received);
    modport slave  (input load, data, valid, output ack, load_received);
endinterface

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: receives framed ROM words over 8N1 UART and hands them to a consumer one at a time
module uart_rom_loader #(
    parameter int CLKS_PER_BIT      = 4,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              uart_rx,
    uart_rom_loader_if.master rom_loader,
    output logic              hack_external_reset,
    output logic              busy,
    output logic              error
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_HOLD} rx_state_t;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, WAIT_RECV, DATA_LO, DATA_HI, WAIT_ACK, DONE} state_t;

    rx_state_t rx_state, rx_next;
    state_t    state, state_n;
    logic                         s1, s2, s3, tick, byte_valid, frame_err;
    logic [CW-1:0]                rx_cnt;
    logic [2:0]                   rx_bit;
    logic [7:0]                   rx_byte, buf_data, cnt_lo, lo_byte, cur;
    logic [15:0]                  remaining;
    logic [INSTRUCTION_WIDTH-1:0] data_q;
    logic buf_valid, word_pending, done_cnt, have, consuming, overrun, abort, loading;

    assign tick       = rx_cnt == ((rx_state == R_START) ? CW'(HALF - 1) : CW'(CLKS_PER_BIT - 1));
    assign byte_valid = rx_state == R_STOP && tick && s2;
    assign frame_err  = rx_state == R_STOP && tick && !s2;

    // Two-flop synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {s1, s2, s3} <= 3'b111;
        else {s1, s2, s3} <= {uart_rx, s1, s2};

    // RX next state: mid-start glitch check, 8 data bits, stop check, wait for idle after a bad stop
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (s3 && !s2) rx_next = R_START;
            R_START: if (tick) rx_next = s2 ? R_IDLE : R_DATA;
            R_DATA:  if (tick && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:  if (tick) rx_next = s2 ? R_IDLE : R_HOLD;
            R_HOLD:  if (s2) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // RX state, bit timer and LSB-first shift register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == R_IDLE || tick) ? '0 : rx_cnt + 1'b1;
            if (rx_state == R_DATA && tick) begin
                rx_byte <= {s2, rx_byte[7:1]};
                rx_bit  <= rx_bit + 1'b1;
            end
        end

    // Byte-consuming states take the buffered byte first; the others only stash into the 1-byte buffer
    assign consuming = state inside {IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI};
    assign have      = buf_valid || byte_valid;
    assign cur       = buf_valid ? buf_data : rx_byte;
    assign overrun   = !consuming && buf_valid && byte_valid;
    assign abort     = state != IDLE && (frame_err || overrun);
    assign loading   = state inside {WAIT_RECV, DATA_LO, DATA_HI, WAIT_ACK, DONE};

    assign rom_loader.load  = loading;
    assign rom_loader.data  = data_q;
    assign rom_loader.valid = word_pending;
    assign hack_external_reset = loading;
    assign busy = state != IDLE;

    // Session FSM next state; any abort returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (have && cur == 8'hA5) state_n = CNT_LO;
            CNT_LO:    if (have) state_n = CNT_HI;
            CNT_HI:    if (have) state_n = ({cur, cnt_lo} == 16'd0) ? IDLE : WAIT_RECV;
            WAIT_RECV: if (rom_loader.load_received) state_n = DATA_LO;
            DATA_LO:   if (have) state_n = DATA_HI;
            DATA_HI:   if (have) state_n = WAIT_ACK;
            WAIT_ACK:  if (rom_loader.ack && word_pending) state_n = (remaining > 16'd1) ? DATA_LO : DONE;
            DONE:      if (done_cnt) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // Session FSM state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    // Byte buffer, count, word assembly, handshake and sticky error
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            buf_valid    <= 1'b0;
            buf_data     <= '0;
            cnt_lo       <= '0;
            lo_byte      <= '0;
            remaining    <= '0;
            data_q       <= '0;
            word_pending <= 1'b0;
            done_cnt     <= 1'b0;
            error        <= 1'b0;
        end else if (abort) begin
            buf_valid    <= 1'b0;
            word_pending <= 1'b0;
            error        <= 1'b1;
            done_cnt     <= 1'b0;
        end else begin
            if (consuming && buf_valid) buf_valid <= byte_valid;
            if (byte_valid && (buf_valid || !consuming)) buf_data <= rx_byte;
            if (!consuming && byte_valid) buf_valid <= 1'b1;
            if (state == IDLE && have && cur == 8'hA5) error <= 1'b0;
            if (state == CNT_LO && have) cnt_lo <= cur;
            if (state == CNT_HI && have) remaining <= {cur, cnt_lo};
            if (state == DATA_LO && have) lo_byte <= cur;
            if (state == DATA_HI && have) begin
                data_q       <= {cur, lo_byte};
                word_pending <= 1'b1;
            end
            if (state == WAIT_ACK && rom_loader.ack && word_pending) begin
                word_pending <= 1'b0;
                remaining    <= remaining - 16'(remaining != 16'd0);
            end
            done_cnt <= state == DONE && !done_cnt;
        end
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: serial stimulus with a word scoreboard checked by an independent monitor
module tb_uart_rom_loader;
    localparam int CPB = 4;

    logic clk = 0, reset_n = 0, uart_rx = 1;
    logic hack_external_reset, busy, error;
    logic ack_q = 0, force_ack = 0, ack_en = 1;
    logic prev_valid = 0, prev_load = 0;
    logic [31:0] mon_exp;
    logic [15:0] exp_q[$];
    int pass_cnt = 0, total = 0, cyc = 0, last_ack = 0, fall_cyc = 0, load_rises = 0, r;

    uart_rom_loader_if rl();
    assign rl.ack = ack_q | force_ack;

    uart_rom_loader #(.CLKS_PER_BIT(CPB), .INSTRUCTION_WIDTH(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .uart_rx(uart_rx),
        .rom_loader(rl),
        .hack_external_reset(hack_external_reset),
        .busy(busy),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop = 1'b0);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = ~bad_stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    // Edge counter and the edge at which the last ack was sampled
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rl.ack) last_ack <= cyc + 1;
    end

    // Monitor: every new word pops the scoreboard; also tracks load edges
    always @(negedge clk) begin
        prev_valid <= rl.valid;
        prev_load  <= rl.load;
        if (rl.load && !prev_load) load_rises <= load_rises + 1;
        if (prev_load && !rl.load) fall_cyc <= cyc;
        if (rl.valid && !prev_valid) begin
            mon_exp = (exp_q.size() != 0) ? {16'h0, exp_q.pop_front()} : 32'hDEAD_BEEF;
            check("word", {16'h0, rl.data}, mon_exp);
        end
    end

    // Consumer: acks each word a few clocks after it appears
    initial forever begin
        @(negedge clk);
        if (rl.valid && ack_en) begin
            repeat (2) @(negedge clk);
            ack_q = 1'b1;
            @(negedge clk);
            ack_q = 1'b0;
        end
    end

    initial begin
        rl.load_received = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_load", rl.load, 0);
        check("rst_hack", hack_external_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_data", rl.data, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        send_byte(8'hA5);
        send_byte(8'h02);
        check("cnt_lo_busy", busy, 1);
        check("cnt_lo_load", rl.load, 0);
        send_byte(8'h00);
        check("cnt_hi_load", rl.load, 1);
        check("cnt_hi_hack", hack_external_reset, 1);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h78);
        send_byte(8'h56);
        wait_idle("two_word_idle");
        check("ack_to_drop", fall_cyc - last_ack, 2);
        check("two_word_error", error, 0);
        check("two_word_queue", exp_q.size(), 0);
        check("two_word_rises", load_rises, 1);

        r = load_rises;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle("zero_idle");
        check("zero_no_load", load_rises, r);
        check("zero_error", error, 0);

        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_busy", busy, 0);
        exp_q.push_back(16'hFFFF);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hFF);
        wait_idle("glitch_idle");
        check("glitch_error", error, 0);
        check("glitch_queue", exp_q.size(), 0);

        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34, 1'b1);
        check("frame_error", error, 1);
        check("frame_load", rl.load, 0);
        send_byte(8'hA5);
        check("frame_clear", error, 0);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle("frame_idle");

        ack_en = 1'b0;
        exp_q.push_back(16'h2211);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovr_pending_load", rl.load, 1);
        send_byte(8'h33);
        send_byte(8'h44);
        check("ovr_error", error, 1);
        check("ovr_load", rl.load, 0);
        check("ovr_busy", busy, 0);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("stale_ack_busy", busy, 0);
        check("stale_ack_load", rl.load, 0);
        check("stale_ack_valid", rl.valid, 0);
        ack_en = 1'b1;

        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEF);
        check("mid_load", rl.load, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_load", rl.load, 0);
        check("mid_rst_hack", hack_external_reset, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", rl.data, 0);
        check("mid_rst_valid", rl.valid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(16'hABCD);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hCD);
        send_byte(8'hAB);
        wait_idle("after_rst_idle");
        check("after_rst_error", error, 0);
        check("after_rst_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
